mux_4to1_5bit_rr_arbiter: RTL and testbench



---
 rtl/mux_4to1_5bit_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux_4to1_5bit_rr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_5bit_rr_arbiter.sv
// Round-robin arbiter over a 5-bit 4:1 mux with a one-entry output register.
// Define MUX_ARB_PACKET_LOCK_EN to add in_last and hold the grant per packet.
module mux_4to1_5bit_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_valid,
    input  logic [4:0] in0,
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    input  logic [4:0] in3,
`ifdef MUX_ARB_PACKET_LOCK_EN
    input  logic [3:0] in_last,
`endif
    output logic [3:0] in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_data,
    output logic [1:0] out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] data_q, data_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
`ifdef MUX_ARB_PACKET_LOCK_EN
    logic       lock_q, lock_d;
    logic [1:0] lock_id_q, lock_id_d;
`endif

    logic       load;
    logic       found;
    logic       accept;
    logic [1:0] win;
    logic [4:0] word;

    assign load   = (state_q == EMPTY) || out_ready;
    assign accept = rst_n && load && found;

    always_comb begin : pick
        logic [1:0] idx;
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && in_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
`ifdef MUX_ARB_PACKET_LOCK_EN
        // a locked grant blocks everyone else, even when its owner idles
        if (lock_q) begin
            win   = lock_id_q;
            found = in_valid[lock_id_q];
        end
`endif
    end

    always_comb begin
        in_ready = 4'b0000;
        if (accept)
            in_ready[win] = 1'b1;
    end

    always_comb begin
        word = in0;
        unique case (win)
            2'd0: word = in0;
            2'd1: word = in1;
            2'd2: word = in2;
            2'd3: word = in3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef MUX_ARB_PACKET_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
`endif
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (!accept && out_ready) state_d = EMPTY;
        endcase
        if (accept) begin
            data_d = word;
            sel_d  = win;
`ifdef MUX_ARB_PACKET_LOCK_EN
            if (in_last[win]) begin
                lock_d = 1'b0;
                ptr_d  = win + 2'd1;
            end else begin
                lock_d    = 1'b1;
                lock_id_d = win;
            end
`else
            ptr_d = win + 2'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= 5'd0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
`ifdef MUX_ARB_PACKET_LOCK_EN
            lock_q    <= 1'b0;
            lock_id_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef MUX_ARB_PACKET_LOCK_EN
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_4to1_5bit_rr_arbiter.sv
// Bench for mux_4to1_5bit_rr_arbiter: vector table, directed corner
// sequences and random traffic against a priority-queue reference model.
module tb_mux_4to1_5bit_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_valid = 4'b0000;
    logic [4:0] in0 = 5'd1;
    logic [4:0] in1 = 5'd2;
    logic [4:0] in2 = 5'd3;
    logic [4:0] in3 = 5'd4;
    logic       out_ready = 1'b0;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [4:0] out_data;
    logic [1:0] out_sel;
`ifdef MUX_ARB_PACKET_LOCK_EN
    logic [3:0] in_last = 4'b1111;
`endif

    int errors = 0;
    int checks = 0;

    mux_4to1_5bit_rr_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3),
`ifdef MUX_ARB_PACKET_LOCK_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] sel;
        logic [4:0] data;
    } vec_t;

    vec_t tbl[14];

    int prio[$];
    logic       ov_m;
    logic [4:0] data_m;
    logic [1:0] sel_m;
    logic       lock_m;
    int         lid_m;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [3:0] iv,
                        input logic ordy, input logic [3:0] rdy,
                        input logic ov, input logic [1:0] sel,
                        input logic [4:0] d);
        in_valid  = iv;
        out_ready = ordy;
        #1;
        chk({nm, "_in_ready"}, int'(in_ready), int'(rdy));
        @(posedge clk);
        #1;
        chk({nm, "_out_valid"}, int'(out_valid), int'(ov));
        chk({nm, "_out_sel"}, int'(out_sel), int'(sel));
        chk({nm, "_out_data"}, int'(out_data), int'(d));
    endtask

    task automatic rot(input int w);
        while (prio[0] != w)
            prio.push_back(prio.pop_front());
        prio.push_back(prio.pop_front());
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd2};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd3};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd4};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 5'd1};
        tbl[6]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 5'd4};
        tbl[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3, 5'd4};
        tbl[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd3};
        tbl[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd4};
        tbl[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 5'd1};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 5'd1};

        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sel", int'(out_sel), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            step($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].ordy,
                 tbl[i].rdy, tbl[i].ov, tbl[i].sel, tbl[i].data);

        in2 = 5'd17;
        step("stall_acc", 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd17);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 5'd17);
        step("stall_drain", 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd17);
        step("stall_empty", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 5'd17);
        in2 = 5'd3;

        step("rr_pre3", 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd4);
        step("rr_pre0", 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1);
        step("rr_g1", 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd2);
        step("rr_g2", 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd3);
        step("rr_g0", 4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1);
        step("rr_g1b", 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd2);
        step("rr_idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 5'd2);

`ifdef MUX_ARB_PACKET_LOCK_EN
        step("lk_pre2", 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd3);
        step("lk_pre3", 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd4);
        step("lk_pre0", 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1);
        in_last = 4'b1101;
        in1 = 5'd10;
        step("lk_w0", 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd10);
        step("lk_gap", 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd1, 5'd10);
        in1 = 5'd11;
        step("lk_w1", 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd11);
        in1 = 5'd12;
        in_last = 4'b1111;
        step("lk_w2", 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd12);
        step("lk_next", 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd3);
        step("lk_idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 5'd3);
        in1 = 5'd2;
`endif

        step("ar_load", 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd1);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", int'(out_valid), 0);
        chk("ar_out_data", int'(out_data), 0);
        chk("ar_out_sel", int'(out_sel), 0);
        chk("ar_in_ready", int'(in_ready), 0);
        #1 rst_n = 1'b1;
        step("ar_first", 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1);

        prio   = '{1, 2, 3, 0};
        ov_m   = 1'b1;
        data_m = 5'd1;
        sel_m  = 2'd0;
        lock_m = 1'b0;
        lid_m  = 0;
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wd[4];
            logic [3:0] exp_rdy;
            logic       ld;
            logic       last;
            int         w;
            for (int j = 0; j < 4; j++)
                wd[j] = 5'($urandom);
            in0 = wd[0];
            in1 = wd[1];
            in2 = wd[2];
            in3 = wd[3];
            in_valid  = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            last = 1'b1;
`ifdef MUX_ARB_PACKET_LOCK_EN
            in_last = 4'($urandom);
`endif
            w = -1;
            if (lock_m) begin
                if (in_valid[lid_m]) w = lid_m;
            end else begin
                foreach (prio[j])
                    if (w < 0 && in_valid[prio[j]]) w = prio[j];
            end
            ld = !ov_m || out_ready;
            exp_rdy = 4'b0000;
            if (ld && w >= 0) exp_rdy[w] = 1'b1;
            #1;
            chk("rnd_in_ready", int'(in_ready), int'(exp_rdy));
            if (ld && w >= 0) begin
`ifdef MUX_ARB_PACKET_LOCK_EN
                last = in_last[w];
`endif
                ov_m   = 1'b1;
                data_m = wd[w];
                sel_m  = 2'(w);
                if (last) begin
                    lock_m = 1'b0;
                    rot(w);
                end else begin
                    lock_m = 1'b1;
                    lid_m  = w;
                end
            end else if (out_ready) begin
                ov_m = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rnd_out_valid", int'(out_valid), int'(ov_m));
            chk("rnd_out_sel", int'(out_sel), int'(sel_m));
            chk("rnd_out_data", int'(out_data), int'(data_m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
